// File: rtl/or1k_wb_burst_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : or1k_wb_pkg
// Purpose  : Shared Wishbone B3 cycle-type / burst-type encodings, the burst
//            RAM state encoding and the wrap-mask helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package or1k_wb_pkg;

   // Cycle type identifiers (wb_cti_i)
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   // Burst type extensions (wb_bte_i)
   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACTIVE = 2'd2,
      GAP    = 2'd3
   } state_t;

   // Low word-index bits that rotate inside a wrapped burst. Linear bursts
   // return 0 here; the caller treats them as a full-width increment.
   function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
      logic [3:0] m;
      m = 4'b0000;
      case (bte)
         BTE_WRAP4:  m = 4'b0011;
         BTE_WRAP8:  m = 4'b0111;
         BTE_WRAP16: m = 4'b1111;
         default:    m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/or1k_wb_burst_ram_if.sv
`default_nettype none
// ============================================================================
// Module   : or1k_wb_burst_ram_if
// Purpose  : Wishbone B3 bus bundle between an OR1K master port and the
//            burst RAM.
// Ports    : master modport drives adr/dat_i/sel/we/cyc/stb/cti/bte and
//            receives dat_o/ack/err/rty; slave modport is the mirror image.
// Revision : 1.0 - initial release
// ============================================================================
interface or1k_wb_burst_ram_if;
   import or1k_wb_pkg::*;

   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [2:0]  wb_cti_i;
   logic [1:0]  wb_bte_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        wb_rty_o;

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
             wb_cti_i, wb_bte_i,
      output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
   );

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
             wb_cti_i, wb_bte_i,
      input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
   );
endinterface
`default_nettype wire

// File: rtl/or1k_wb_burst_ram_addr.sv
`default_nettype none
// ============================================================================
// Module   : or1k_wb_burst_addr
// Purpose  : Next word index of a Wishbone incrementing burst. Linear bursts
//            increment the full index (wrapping at the memory size); wrapN
//            bursts increment only the low log2(N) bits.
// Ports    : i_baddr  - current word index
//            i_bte    - burst type extension
//            o_next   - word index of the following beat
// Revision : 1.0 - initial release
// ============================================================================
module or1k_wb_burst_addr
   import or1k_wb_pkg::*;
#(
   parameter int AW = 12
) (
   input  wire logic [AW-1:0] i_baddr,
   input  wire logic [1:0]    i_bte,
   output logic      [AW-1:0] o_next
);

   logic [AW-1:0] w_incr;
   logic [AW-1:0] w_mask;

   always_comb begin
      w_incr = i_baddr + AW'(1);
      if (i_bte == BTE_LINEAR) begin
         w_mask = '1;
      end else begin
         w_mask = AW'(wrap_mask(i_bte));
      end
      // Bits outside the mask keep their value; bits inside take the
      // incremented value, so the carry out of the wrap field is dropped.
      o_next = (i_baddr & ~w_mask) | (w_incr & w_mask);
   end

endmodule
`default_nettype wire

// File: rtl/or1k_wb_burst_ram.sv
`default_nettype none
// ============================================================================
// Module   : or1k_wb_burst_ram
// Purpose  : Wishbone B3 slave memory for OR1K instruction/data ports.
//            Classic cycles and incrementing bursts (linear / wrap4/8/16),
//            programmable first-beat wait states, error termination for
//            out-of-range addresses.
// Ports    : clk - rising-edge clock
//            rst - asynchronous reset, active low
//            wb  - Wishbone slave bundle (adr, dat_i, sel, we, cyc, stb,
//                  cti, bte in; dat_o, ack, err, rty out)
// Revision : 1.0 - initial release
// ============================================================================
module or1k_wb_burst_ram
   import or1k_wb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int          MEM_WORDS_LOG2 = 12,
   parameter int          WAIT_STATES    = 0,
   parameter string       MEM_FILE       = ""
) (
   input wire logic           clk,
   input wire logic           rst,
   or1k_wb_burst_ram_if.slave wb
);

   localparam int         c_AW        = MEM_WORDS_LOG2;
   localparam int         c_DEPTH     = 1 << MEM_WORDS_LOG2;
   localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_STATES);

   state_t          state_q, state_d;
   logic [3:0]      wcnt_q, wcnt_d;
   logic            ack_q, ack_d;
   logic            err_q, err_d;
   logic            oor_q, oor_d;
   logic [c_AW-1:0] baddr_q, baddr_d;

   logic [31:0]     mem [c_DEPTH];

   logic            w_req;
   logic [31:0]     w_off;
   logic            w_in_range;
   logic [c_AW-1:0] w_idx;
   logic [c_AW-1:0] w_next;
   logic            w_mem_we;
   logic [1:0]      w_unused_off;

   assign w_req        = wb.wb_cyc_i & wb.wb_stb_i;
   assign w_off        = wb.wb_adr_i - BASE_ADDR;
   assign w_in_range   = (w_off[31:2] >> MEM_WORDS_LOG2) == 30'd0;
   assign w_idx        = w_off[c_AW+1:2];
   // Byte lane within the word is irrelevant: sel picks the bytes.
   assign w_unused_off = w_off[1:0];

   or1k_wb_burst_addr #(
      .AW (c_AW)
   ) u_burst_addr (
      .i_baddr (baddr_q),
      .i_bte   (wb.wb_bte_i),
      .o_next  (w_next)
   );

   // ------------------------------------------------------------------------
   // FSM: next state and registered termination flags
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      ack_d    = ack_q;
      err_d    = err_q;
      oor_d    = oor_q;
      baddr_d  = baddr_q;
      w_mem_we = 1'b0;

      case (state_q)
         IDLE: begin
            ack_d = 1'b0;
            err_d = 1'b0;
            if (w_req) begin
               baddr_d = w_idx;
               oor_d   = ~w_in_range;
               wcnt_d  = c_WAIT_INIT;
               if (c_WAIT_INIT == 4'd0) begin
                  state_d = ACTIVE;
                  ack_d   = w_in_range;
                  err_d   = ~w_in_range;
               end else begin
                  state_d = WAIT;
               end
            end
         end

         WAIT: begin
            if (!wb.wb_cyc_i) begin
               state_d = IDLE;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
               if (wcnt_q == 4'd1) begin
                  state_d = ACTIVE;
                  ack_d   = ~oor_q;
                  err_d   = oor_q;
               end
            end
         end

         ACTIVE: begin
            if (!wb.wb_cyc_i) begin
               state_d = IDLE;
               ack_d   = 1'b0;
               err_d   = 1'b0;
            end else if (wb.wb_stb_i) begin
               // The beat is consumed at this edge. With stb low the flags
               // are simply held, so the beat resumes when stb returns.
               w_mem_we = ack_q & wb.wb_we_i;
               if (err_q) begin
                  state_d = IDLE;
                  ack_d   = 1'b0;
                  err_d   = 1'b0;
               end else if (wb.wb_cti_i == CTI_INCR) begin
                  baddr_d = w_next;
               end else if (wb.wb_cti_i == CTI_EOB) begin
                  state_d = IDLE;
                  ack_d   = 1'b0;
               end else begin
                  // Classic and every unsupported cti value
                  state_d = GAP;
                  ack_d   = 1'b0;
               end
            end
         end

         GAP: begin
            state_d = IDLE;
            ack_d   = 1'b0;
            err_d   = 1'b0;
         end

         default: begin
            state_d = IDLE;
            ack_d   = 1'b0;
            err_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         wcnt_q  <= 4'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         oor_q   <= 1'b0;
         baddr_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         oor_q   <= oor_d;
         baddr_q <= baddr_d;
      end
   end

   // ------------------------------------------------------------------------
   // Memory array: byte-lane writes at the ack edge, contents survive reset
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wb.wb_sel_i[b]) begin
               mem[baddr_q][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
            end
         end
      end
   end

   // Read port is asynchronous on baddr_q, so a beat that follows a write
   // to the same word already sees the committed data.
   assign wb.wb_dat_o = ack_q ? mem[baddr_q] : 32'h0000_0000;
   assign wb.wb_ack_o = ack_q & w_req;
   assign wb.wb_err_o = err_q & w_req;
   assign wb.wb_rty_o = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_or1k_wb_burst_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_or1k_wb_burst_ram
// Purpose  : Directed self-checking bench for or1k_wb_burst_ram. Two
//            instances (0 and 3 wait states) share one stimulus driver; the
//            active one is chosen by cur.
// Revision : 1.0 - initial release
// ============================================================================
module tb_or1k_wb_burst_ram;
   import or1k_wb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   or1k_wb_burst_ram_if bus0 ();
   or1k_wb_burst_ram_if bus3 ();

   logic [31:0] adr   = 32'h0;
   logic [31:0] dat_w = 32'h0;
   logic [3:0]  sel   = 4'h0;
   logic        we    = 1'b0;
   logic        cyc   = 1'b0;
   logic        stb   = 1'b0;
   logic [2:0]  cti   = 3'b000;
   logic [1:0]  bte   = 2'b00;
   int          cur   = 0;

   assign bus0.wb_adr_i = adr;   assign bus3.wb_adr_i = adr;
   assign bus0.wb_dat_i = dat_w; assign bus3.wb_dat_i = dat_w;
   assign bus0.wb_sel_i = sel;   assign bus3.wb_sel_i = sel;
   assign bus0.wb_we_i  = we;    assign bus3.wb_we_i  = we;
   assign bus0.wb_stb_i = stb;   assign bus3.wb_stb_i = stb;
   assign bus0.wb_cti_i = cti;   assign bus3.wb_cti_i = cti;
   assign bus0.wb_bte_i = bte;   assign bus3.wb_bte_i = bte;
   assign bus0.wb_cyc_i = cyc & (cur == 0);
   assign bus3.wb_cyc_i = cyc & (cur == 1);

   logic        o_ack, o_err;
   logic [31:0] o_dat;
   assign o_ack = (cur == 0) ? bus0.wb_ack_o : bus3.wb_ack_o;
   assign o_err = (cur == 0) ? bus0.wb_err_o : bus3.wb_err_o;
   assign o_dat = (cur == 0) ? bus0.wb_dat_o : bus3.wb_dat_o;

   or1k_wb_burst_ram #(
      .BASE_ADDR(32'h0), .MEM_WORDS_LOG2(12), .WAIT_STATES(0), .MEM_FILE("")
   ) dut0 (.clk(clk), .rst(rst), .wb(bus0));

   or1k_wb_burst_ram #(
      .BASE_ADDR(32'h0), .MEM_WORDS_LOG2(12), .WAIT_STATES(3), .MEM_FILE("")
   ) dut3 (.clk(clk), .rst(rst), .wb(bus3));

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic        is_err;
      logic        chk;
      logic [31:0] dat;
   } exp_t;
   exp_t sb[$];

   logic [31:0] mdl [0:1][0:4095];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int ws_of(input int c);
      return (c == 0) ? 0 : 3;
   endfunction

   function automatic logic [11:0] widx(input logic [31:0] a);
      return a[13:2];
   endfunction

   function automatic logic [11:0] nxt(input logic [11:0] w, input logic [1:0] b);
      logic [11:0] r;
      case (b)
         2'b01:   r = {w[11:2], w[1:0] + 2'd1};
         2'b10:   r = {w[11:3], w[2:0] + 3'd1};
         2'b11:   r = {w[11:4], w[3:0] + 4'd1};
         default: r = w + 12'd1;
      endcase
      return r;
   endfunction

   task automatic mdl_write(input logic [11:0] w, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++) begin
         if (s[b]) mdl[cur][w][8*b +: 8] = d[8*b +: 8];
      end
   endtask

   // Scoreboard consumer: every termination on the selected bus must match
   // the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst && (o_ack || o_err)) begin
         tests++;
         assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL sb_unexpected: observed ack=%b err=%b expected no termination", o_ack, o_err);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            tests++;
            assert ({o_ack, o_err} === {~e.is_err, e.is_err}) else begin
               fails++;
               $error("FAIL sb_term: observed ack/err %b%b expected %b%b", o_ack, o_err, ~e.is_err, e.is_err);
            end
            if (e.chk) begin
               tests++;
               assert (o_dat === e.dat) else begin
                  fails++;
                  $error("FAIL sb_data: observed %h expected %h", o_dat, e.dat);
               end
            end
         end
      end
   end

   task automatic classic(input logic w_we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] c, input logic exp_err,
                          input bit gap_chk, input string tag);
      int n;
      logic [11:0] wi;
      wi = widx(a);
      if (exp_err) begin
         sb.push_back({1'b1, 1'b0, 32'h0});
      end else if (w_we) begin
         mdl_write(wi, d, s);
         sb.push_back({1'b0, 1'b0, 32'h0});
      end else begin
         sb.push_back({1'b0, 1'b1, mdl[cur][wi]});
      end
      @(posedge clk); #1;
      adr = a; dat_w = d; sel = s; we = w_we; cti = c; bte = BTE_LINEAR;
      cyc = 1'b1; stb = 1'b1;
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (!(o_ack || o_err) && n < 40);
      chk({tag, " latency"}, n, 2 + ws_of(cur));
      @(posedge clk); #1;
      if (gap_chk) begin
         @(negedge clk);
         chk({tag, " gap"}, {30'd0, o_ack, o_err}, 32'd0);
         @(posedge clk); #1;
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
   endtask

   task automatic burst(input logic w_we, input logic [31:0] a, input logic [1:0] b,
                        input int nb, input logic [31:0] seed, input int stall_at,
                        input string tag, output int first, output int last);
      int n, beat;
      bit stalled;
      logic [11:0] w;
      w = widx(a);
      for (int i = 0; i < nb; i++) begin
         if (w_we) begin
            mdl_write(w, seed + i, 4'hF);
            sb.push_back({1'b0, 1'b0, 32'h0});
         end else begin
            sb.push_back({1'b0, 1'b1, mdl[cur][w]});
         end
         w = nxt(w, b);
      end
      @(posedge clk); #1;
      adr = a; we = w_we; bte = b; sel = 4'hF; dat_w = seed;
      cti = (nb == 1) ? CTI_EOB : CTI_INCR;
      cyc = 1'b1; stb = 1'b1;
      n = 0; beat = 0; first = 0; last = 0; stalled = 1'b0;
      while (beat < nb && n < 200) begin
         @(negedge clk); n++;
         if (o_ack || o_err) begin
            if (beat == 0) first = n;
            last = n;
            beat++;
         end
         @(posedge clk); #1;
         dat_w = seed + beat;
         cti   = (beat == nb - 1) ? CTI_EOB : CTI_INCR;
         if (beat == stall_at && !stalled && beat < nb) begin
            stalled = 1'b1;
            stb = 1'b0;
            repeat (2) begin
               @(negedge clk);
               chk({tag, " stall"}, {30'd0, o_ack, o_err}, 32'd0);
               @(posedge clk); #1;
            end
            stb = 1'b1;
         end
      end
      chk({tag, " beats"}, beat, nb);
      cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int f, l, n;

      // Reset values on both instances
      repeat (3) @(posedge clk);
      #1;
      chk("rst ack0",  {31'd0, bus0.wb_ack_o}, 32'd0);
      chk("rst err0",  {31'd0, bus0.wb_err_o}, 32'd0);
      chk("rst dat0",  bus0.wb_dat_o, 32'd0);
      chk("rst rty0",  {31'd0, bus0.wb_rty_o}, 32'd0);
      chk("rst dat3",  bus3.wb_dat_o, 32'd0);
      chk("rst ack3",  {31'd0, bus3.wb_ack_o}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Preload and classic read: ack on cycle 2, low on cycle 3
      cur = 0;
      classic(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, CTI_CLASSIC, 1'b0, 1'b0, "wr40");
      classic(1'b1, 32'h44, 32'h1122_3344, 4'hF, CTI_CLASSIC, 1'b0, 1'b0, "wr44");
      classic(1'b0, 32'h40, 32'h0, 4'hF, CTI_CLASSIC, 1'b0, 1'b1, "rd40");

      // Byte lane write then read back
      classic(1'b1, 32'h44, 32'h0000_AB00, 4'b0010, CTI_CLASSIC, 1'b0, 1'b0, "bytewr");
      classic(1'b0, 32'h44, 32'h0, 4'hF, CTI_CLASSIC, 1'b0, 1'b1, "byterd");
      chk("byte model", mdl[0][12'h11], 32'h1122_AB44);

      // Unsupported cti behaves as classic (single ack then idle gap)
      classic(1'b0, 32'h40, 32'h0, 4'hF, 3'b101, 1'b0, 1'b1, "cti101");

      // Wrap4 from word 6: words 6,7,4,5 with consecutive acks
      burst(1'b1, 32'h10, BTE_LINEAR, 4, 32'hA000_0004, -1, "fill4", f, l);
      burst(1'b0, 32'h18, BTE_WRAP4, 4, 32'h0, -1, "wrap4", f, l);
      chk("wrap4 first", f, 2);
      chk("wrap4 b2b", l - f, 3);
      classic(1'b0, 32'h1C, 32'h0, 4'hF, CTI_CLASSIC, 1'b0, 1'b0, "postwrap");

      // Wrap8 read with a master stall in the middle
      burst(1'b1, 32'h80, BTE_LINEAR, 8, 32'hB000_0020, -1, "fill8", f, l);
      burst(1'b0, 32'h94, BTE_WRAP8, 8, 32'h0, 3, "wrap8", f, l);

      // Out-of-range write: err only, aliased word untouched
      classic(1'b1, 32'h0, 32'h5A5A_0000, 4'hF, CTI_CLASSIC, 1'b0, 1'b0, "wr0");
      classic(1'b1, 32'h4000, 32'hFFFF_FFFF, 4'hF, CTI_CLASSIC, 1'b1, 1'b0, "oor");
      classic(1'b0, 32'h0, 32'h0, 4'hF, CTI_CLASSIC, 1'b0, 1'b0, "rd0");

      // Linear burst across the top of memory wraps to word 0
      burst(1'b1, 32'h3FFC, BTE_LINEAR, 3, 32'hC000_0000, -1, "topwr", f, l);
      classic(1'b0, 32'h0, 32'h0, 4'hF, CTI_CLASSIC, 1'b0, 1'b0, "toprd0");
      chk("top model w0", mdl[0][12'h000], 32'hC000_0001);
      burst(1'b0, 32'h3FFC, BTE_LINEAR, 3, 32'h0, -1, "toprd", f, l);

      // Three wait states: 8-beat linear burst
      cur = 1;
      burst(1'b1, 32'h200, BTE_LINEAR, 8, 32'hD000_0000, -1, "ws3wr", f, l);
      burst(1'b0, 32'h200, BTE_LINEAR, 8, 32'h0, -1, "ws3rd", f, l);
      chk("ws3 first ack", f - 1, 4);
      chk("ws3 span", l - 1, 11);
      classic(1'b0, 32'h204, 32'h0, 4'hF, CTI_CLASSIC, 1'b0, 1'b1, "ws3cl");

      // Reset during beat 2 of a 4-beat burst
      cur = 0;
      burst(1'b1, 32'h100, BTE_LINEAR, 4, 32'hE000_0000, -1, "rstfill", f, l);
      sb.push_back({1'b0, 1'b1, mdl[0][12'h040]});
      sb.push_back({1'b0, 1'b1, mdl[0][12'h041]});
      @(posedge clk); #1;
      adr = 32'h100; we = 1'b0; bte = BTE_LINEAR; sel = 4'hF; cti = CTI_INCR;
      cyc = 1'b1; stb = 1'b1;
      n = 0; f = 0;
      while (f < 2 && n < 40) begin
         @(negedge clk); n++;
         if (o_ack || o_err) f++;
      end
      chk("rst burst beats", f, 2);
      #1 rst = 1'b0;
      #1;
      chk("rst mid ack/err", {30'd0, o_ack, o_err}, 32'd0);
      chk("rst mid dat", o_dat, 32'd0);
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; cti = CTI_CLASSIC;
      @(posedge clk); #1;
      rst = 1'b1;
      classic(1'b0, 32'h108, 32'h0, 4'hF, CTI_CLASSIC, 1'b0, 1'b1, "postrst");

      repeat (3) @(posedge clk);
      chk("sb empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
